// File: rtl/alu_fetch.sv
// alu_fetch: combinational 32-bit ALU plus a single-outstanding bus fetch FSM.
// The ALU is independent of clock and reset; the FSM bridges f_* requests to W_* bus.
module alu_fetch (
    input  logic        clk,
    input  logic        W_RST,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic        alu_carry,
    output logic [31:0] alu_summ,
    output logic        alu_ocarry,
    output logic [31:0] alu_sub,
    output logic [31:0] alu_mult_h,
    output logic [31:0] alu_mult_l,
    output logic [31:0] alu_zand,
    output logic [31:0] alu_zor,
    output logic [31:0] alu_zxor,
    output logic [31:0] alu_znot,
    output logic [31:0] alu_ashiftl,
    output logic [31:0] alu_ashiftr,
    output logic [31:0] alu_lshiftl,
    output logic [31:0] alu_lshiftr,
    output logic [31:0] alu_revers,
    input  logic        f_enable,
    input  logic        f_write_enable,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_data_i,
    input  logic [1:0]  f_thread,
    output logic [31:0] f_data_o,
    output logic        f_ack,
    output logic [31:0] W_ADDR,
    output logic [31:0] W_DATA_O,
    output logic        W_WRITE,
    output logic        W_STB,
    input  logic [31:0] W_DATA_I,
    input  logic        W_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [32:0] sum_ext;
    logic [63:0] prod;
    logic [4:0]  shamt;

    assign shamt   = alu_b[4:0];
    assign sum_ext = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry};
    assign prod    = $signed(alu_a) * $signed(alu_b);

    assign alu_summ    = sum_ext[31:0];
    assign alu_ocarry  = sum_ext[32];
    assign alu_sub     = alu_a - alu_b;
    assign alu_mult_h  = prod[63:32];
    assign alu_mult_l  = prod[31:0];
    assign alu_zand    = alu_a & alu_b;
    assign alu_zor     = alu_a | alu_b;
    assign alu_zxor    = alu_a ^ alu_b;
    assign alu_znot    = ~alu_a;
    assign alu_ashiftl = alu_a << shamt;
    assign alu_ashiftr = $signed(alu_a) >>> shamt;
    assign alu_lshiftl = alu_a << shamt;
    assign alu_lshiftr = alu_a >> shamt;

    always_comb begin
        alu_revers = '0;
        for (int i = 0; i < 32; i++) begin
            alu_revers[31-i] = alu_a[i];
        end
    end

    // Thread tag is carried for future use only.
    logic unused_thread;
    assign unused_thread = ^f_thread;

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            state    <= IDLE;
            W_ADDR   <= '0;
            W_DATA_O <= '0;
            W_WRITE  <= 1'b0;
            W_STB    <= 1'b0;
            f_ack    <= 1'b0;
            f_data_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    f_ack <= 1'b0;
                    if (f_enable) begin
                        W_ADDR   <= f_addr;
                        W_DATA_O <= f_data_i;
                        W_WRITE  <= f_write_enable;
                        W_STB    <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (W_ACK) begin
                        W_STB <= 1'b0;
                        f_ack <= 1'b1;
                        if (!W_WRITE) begin
                            f_data_o <= W_DATA_I;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    f_ack   <= 1'b0;
                    W_WRITE <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    W_STB   <= 1'b0;
                    W_WRITE <= 1'b0;
                    f_ack   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_fetch.sv
// Directed bench for alu_fetch: ALU vectors and fetch FSM bus sequences.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_fetch;

    logic        clk;
    logic        W_RST;
    logic [31:0] alu_a, alu_b;
    logic        alu_carry;
    logic [31:0] alu_summ, alu_sub, alu_mult_h, alu_mult_l;
    logic        alu_ocarry;
    logic [31:0] alu_zand, alu_zor, alu_zxor, alu_znot;
    logic [31:0] alu_ashiftl, alu_ashiftr, alu_lshiftl, alu_lshiftr;
    logic [31:0] alu_revers;
    logic        f_enable, f_write_enable;
    logic [31:0] f_addr, f_data_i, f_data_o;
    logic [1:0]  f_thread;
    logic        f_ack;
    logic [31:0] W_ADDR, W_DATA_O, W_DATA_I;
    logic        W_WRITE, W_STB, W_ACK;

    int checks = 0;
    int errors = 0;

    alu_fetch dut (
        .clk(clk), .W_RST(W_RST),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry(alu_carry),
        .alu_summ(alu_summ), .alu_ocarry(alu_ocarry), .alu_sub(alu_sub),
        .alu_mult_h(alu_mult_h), .alu_mult_l(alu_mult_l),
        .alu_zand(alu_zand), .alu_zor(alu_zor), .alu_zxor(alu_zxor),
        .alu_znot(alu_znot),
        .alu_ashiftl(alu_ashiftl), .alu_ashiftr(alu_ashiftr),
        .alu_lshiftl(alu_lshiftl), .alu_lshiftr(alu_lshiftr),
        .alu_revers(alu_revers),
        .f_enable(f_enable), .f_write_enable(f_write_enable),
        .f_addr(f_addr), .f_data_i(f_data_i), .f_thread(f_thread),
        .f_data_o(f_data_o), .f_ack(f_ack),
        .W_ADDR(W_ADDR), .W_DATA_O(W_DATA_O), .W_WRITE(W_WRITE),
        .W_STB(W_STB), .W_DATA_I(W_DATA_I), .W_ACK(W_ACK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_set(input logic [31:0] a, input logic [31:0] b,
                           input logic c);
        alu_a = a;
        alu_b = b;
        alu_carry = c;
        #1;
    endtask

    initial begin
        W_RST = 1'b0;
        alu_a = '0; alu_b = '0; alu_carry = 1'b0;
        f_enable = 1'b0; f_write_enable = 1'b0;
        f_addr = '0; f_data_i = '0; f_thread = 2'd0;
        W_DATA_I = '0; W_ACK = 1'b0;

        tick();
        chk("rst_stb", W_STB, 0);
        chk("rst_write", W_WRITE, 0);
        chk("rst_ack", f_ack, 0);
        chk("rst_addr", W_ADDR, 0);
        chk("rst_wdata", W_DATA_O, 0);
        chk("rst_fdata", f_data_o, 0);

        // ALU vectors
        alu_set(32'hFFFFFFFF, 32'h00000001, 1'b0);
        chk("summ_wrap", alu_summ, 32'h00000000);
        chk("ocarry_wrap", alu_ocarry, 1);
        chk("sub_wrap", alu_sub, 32'hFFFFFFFE);

        alu_set(32'h00000001, 32'h00000002, 1'b1);
        chk("summ_cin", alu_summ, 32'h00000004);
        chk("ocarry_cin", alu_ocarry, 0);

        alu_set(32'hFFFFFFFF, 32'h00000000, 1'b1);
        chk("summ_cin_wrap", alu_summ, 32'h00000000);
        chk("ocarry_cin_wrap", alu_ocarry, 1);

        alu_set(32'h80000000, 32'h00000024, 1'b0);
        chk("ashiftr4", alu_ashiftr, 32'hF8000000);
        chk("lshiftr4", alu_lshiftr, 32'h08000000);
        chk("lshiftl4", alu_lshiftl, 32'h00000000);
        chk("ashiftl4", alu_ashiftl, 32'h00000000);
        chk("revers_msb", alu_revers, 32'h00000001);

        alu_set(32'hFFFFFFFD, 32'h00000007, 1'b0);
        chk("mult_neg", {alu_mult_h, alu_mult_l}, 64'hFFFFFFFF_FFFFFFEB);

        alu_set(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        chk("mult_pos", {alu_mult_h, alu_mult_l}, 64'h3FFFFFFF_00000001);

        alu_set(32'h0F0F0F0F, 32'h00FF00FF, 1'b0);
        chk("znot", alu_znot, 32'hF0F0F0F0);
        chk("zand", alu_zand, 32'h000F000F);
        chk("zor", alu_zor, 32'h0FFF0FFF);
        chk("zxor", alu_zxor, 32'h0FF00FF0);

        alu_set(32'h92345678, 32'hFFFFFFE0, 1'b0);
        chk("ashiftr0", alu_ashiftr, 32'h92345678);
        chk("lshiftr0", alu_lshiftr, 32'h92345678);
        chk("lshiftl0", alu_lshiftl, 32'h92345678);

        alu_set(32'h92345678, 32'hFFFFFFE8, 1'b0);
        chk("ashiftr8_hi", alu_ashiftr, 32'hFF923456);
        chk("lshiftl8_hi", alu_lshiftl, 32'h34567800);
        chk("revers_pat", alu_revers, 32'h1E6A2C49);

        W_RST = 1'b1;
        tick();

        // Read with ack three cycles after strobe
        f_enable = 1'b1; f_write_enable = 1'b0; f_addr = 32'h100;
        tick();
        chk("rd_stb1", W_STB, 1);
        chk("rd_addr", W_ADDR, 32'h100);
        chk("rd_write", W_WRITE, 0);
        f_enable = 1'b0; f_addr = 32'hBAD; f_write_enable = 1'b1;
        tick();
        chk("rd_stb2", W_STB, 1);
        chk("rd_ack_early", f_ack, 0);
        tick();
        chk("rd_stb3", W_STB, 1);
        chk("rd_addr_hold", W_ADDR, 32'h100);
        chk("rd_write_hold", W_WRITE, 0);
        W_ACK = 1'b1; W_DATA_I = 32'hDEADBEEF;
        tick();
        chk("rd_stb_drop", W_STB, 0);
        chk("rd_fack", f_ack, 1);
        chk("rd_data", f_data_o, 32'hDEADBEEF);
        W_ACK = 1'b0; W_DATA_I = 32'h0;
        tick();
        chk("rd_fack_clr", f_ack, 0);
        chk("rd_data_hold", f_data_o, 32'hDEADBEEF);

        // Write keeps previous read data
        f_enable = 1'b1; f_write_enable = 1'b1;
        f_addr = 32'h20; f_data_i = 32'h12345678;
        tick();
        chk("wr_stb", W_STB, 1);
        chk("wr_write", W_WRITE, 1);
        chk("wr_addr", W_ADDR, 32'h20);
        chk("wr_wdata", W_DATA_O, 32'h12345678);
        f_enable = 1'b0; f_data_i = 32'h0;
        W_ACK = 1'b1; W_DATA_I = 32'h55555555;
        tick();
        chk("wr_fack", f_ack, 1);
        chk("wr_data_keep", f_data_o, 32'hDEADBEEF);
        W_ACK = 1'b0;
        tick();
        chk("wr_write_clr", W_WRITE, 0);
        chk("wr_fack_clr", f_ack, 0);

        // Ack ignored in IDLE
        W_ACK = 1'b1; W_DATA_I = 32'hCAFEF00D;
        tick();
        tick();
        chk("idle_ack_fack", f_ack, 0);
        chk("idle_ack_stb", W_STB, 0);

        // Minimum latency and back-to-back with ack held high
        f_enable = 1'b1; f_write_enable = 1'b0; f_addr = 32'h4;
        tick();
        chk("min_stb", W_STB, 1);
        chk("min_fack0", f_ack, 0);
        tick();
        chk("min_fack1", f_ack, 1);
        chk("min_data", f_data_o, 32'hCAFEF00D);
        W_DATA_I = 32'h11112222;
        tick();
        chk("done_fack", f_ack, 0);
        chk("done_stb", W_STB, 0);
        chk("done_data", f_data_o, 32'hCAFEF00D);
        f_addr = 32'h8;
        tick();
        chk("b2b_stb", W_STB, 1);
        chk("b2b_addr", W_ADDR, 32'h8);
        f_enable = 1'b0;
        tick();
        chk("b2b_fack", f_ack, 1);
        chk("b2b_data", f_data_o, 32'h11112222);
        W_ACK = 1'b0;
        tick();
        tick();

        // Reset mid-transaction
        f_enable = 1'b1; f_write_enable = 1'b1;
        f_addr = 32'h40; f_data_i = 32'hA5A5A5A5;
        tick();
        chk("ab_stb", W_STB, 1);
        f_enable = 1'b0;
        #2;
        W_RST = 1'b0;
        alu_a = 32'h00000003; alu_b = 32'h00000004;
        #1;
        chk("ab_stb_async", W_STB, 0);
        chk("ab_write", W_WRITE, 0);
        chk("ab_addr", W_ADDR, 0);
        chk("ab_fdata", f_data_o, 0);
        chk("ab_alu_live", alu_summ, 32'h00000007);
        W_ACK = 1'b1;
        tick();
        chk("ab_fack_rst", f_ack, 0);
        #2;
        W_RST = 1'b1;
        tick();
        chk("ab_fack_idle", f_ack, 0);
        chk("ab_stb_idle", W_STB, 0);
        tick();
        chk("ab_fack_idle2", f_ack, 0);
        W_ACK = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
